// File: rtl/gemm_pkg.sv
// Shared types for the GEMM datapath: MAC PE feeder sequencer states.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CAPTURE,
    OUTPUT
  } mac_feeder_state_e;

endpackage

// File: rtl/general_mac_pe.sv
// Output-stationary MAC PE: accumulates the dot product of each valid operand beat into c_o.
module general_mac_pe #(
  parameter int unsigned InDataWidth  = 8,
  parameter int unsigned NumInputs    = 1,
  parameter int unsigned OutDataWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumInputs-1:0][InDataWidth-1:0]    a_i,
  input  logic [NumInputs-1:0][InDataWidth-1:0]    b_i,
  input  logic                                     a_valid_i,
  input  logic                                     b_valid_i,
  input  logic                                     init_save_i,
  input  logic                                     acc_clr_i,
  output logic [OutDataWidth-1:0]                  c_o
);

  logic signed [2*InDataWidth-1:0] prod [NumInputs];
  logic signed [OutDataWidth-1:0]  dot;
  logic signed [OutDataWidth-1:0]  c_q, c_d;

  for (genvar g = 0; g < NumInputs; g++) begin : g_mul
    assign prod[g] = $signed({{InDataWidth{a_i[g][InDataWidth-1]}}, a_i[g]}) *
                     $signed({{InDataWidth{b_i[g][InDataWidth-1]}}, b_i[g]});
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < NumInputs; i++) begin
      dot = dot + OutDataWidth'(prod[i]);
    end
  end

  // init_save restarts the accumulation from the first beat's products.
  always_comb begin
    c_d = c_q;
    if (acc_clr_i) begin
      c_d = '0;
    end else if (a_valid_i && b_valid_i) begin
      c_d = init_save_i ? dot : c_q + dot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/mac_pe_feeder.sv
// Sequences one K-beat dot-product job through a MAC PE, then captures and clears its accumulator.
module mac_pe_feeder
  import gemm_pkg::*;
#(
  parameter int unsigned InDataWidth  = 8,
  parameter int unsigned NumInputs    = 1,
  parameter int unsigned OutDataWidth = 32,
  parameter int unsigned MaxK         = 256,
  parameter int unsigned KWidth       = $clog2(MaxK + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [KWidth-1:0]                     k_beats_i,
  output logic                                  busy_o,
  input  logic [NumInputs-1:0][InDataWidth-1:0] op_a_i,
  input  logic [NumInputs-1:0][InDataWidth-1:0] op_b_i,
  input  logic                                  op_valid_i,
  output logic                                  op_ready_o,
  output logic [NumInputs-1:0][InDataWidth-1:0] pe_a_o,
  output logic [NumInputs-1:0][InDataWidth-1:0] pe_b_o,
  output logic                                  pe_a_valid_o,
  output logic                                  pe_b_valid_o,
  output logic                                  pe_init_save_o,
  output logic                                  pe_acc_clr_o,
  input  logic [OutDataWidth-1:0]               pe_c_i,
  output logic [OutDataWidth-1:0]               res_o,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i
);

  mac_feeder_state_e        state_q, state_d;
  logic [KWidth-1:0]        cnt_q, cnt_d;
  logic                     first_q, first_d;
  logic                     zero_job_q, zero_job_d;
  logic [OutDataWidth-1:0]  res_q, res_d;
  logic [KWidth-1:0]        k_clamped;
  logic                     beat_fire;

  assign k_clamped = (k_beats_i > KWidth'(MaxK)) ? KWidth'(MaxK) : k_beats_i;
  assign beat_fire = (state_q == STREAM) && op_valid_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    zero_job_d     = zero_job_q;
    res_d          = res_q;
    pe_acc_clr_o   = 1'b0;
    pe_init_save_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = k_clamped;
          first_d = 1'b1;
          if (k_clamped == '0) begin
            state_d    = CAPTURE;
            zero_job_d = 1'b1;
          end else begin
            state_d    = STREAM;
            zero_job_d = 1'b0;
          end
        end
      end
      STREAM: begin
        pe_init_save_o = beat_fire && first_q;
        if (beat_fire) begin
          cnt_d   = cnt_q - KWidth'(1);
          first_d = 1'b0;
          if (cnt_q == KWidth'(1)) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // Valids are low here, so the clear wins and the next job starts from 0.
        res_d        = zero_job_q ? '0 : pe_c_i;
        pe_acc_clr_o = 1'b1;
        first_d      = 1'b0;
        zero_job_d   = 1'b0;
        state_d      = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      zero_job_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      zero_job_q <= zero_job_d;
      res_q      <= res_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign op_ready_o   = (state_q == STREAM);
  assign pe_a_o       = op_a_i;
  assign pe_b_o       = op_b_i;
  assign pe_a_valid_o = beat_fire;
  assign pe_b_valid_o = beat_fire;
  assign res_o        = res_q;
  assign res_valid_o  = (state_q == OUTPUT);

endmodule

// File: tb/tb_mac_pe_feeder.sv
// Directed bench: mac_pe_feeder driving a general_mac_pe, with hand-computed dot products.
module tb_mac_pe_feeder;

  localparam int unsigned InW  = 8;
  localparam int unsigned NIn  = 1;
  localparam int unsigned OutW = 32;
  localparam int unsigned MaxK = 256;
  localparam int unsigned KW   = $clog2(MaxK + 1);

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       start_i;
  logic [KW-1:0]              k_beats_i;
  logic                       busy_o;
  logic [NIn-1:0][InW-1:0]    op_a_i, op_b_i;
  logic                       op_valid_i;
  logic                       op_ready_o;
  logic [NIn-1:0][InW-1:0]    pe_a_o, pe_b_o;
  logic                       pe_a_valid_o, pe_b_valid_o;
  logic                       pe_init_save_o, pe_acc_clr_o;
  logic [OutW-1:0]            pe_c;
  logic [OutW-1:0]            res_o;
  logic                       res_valid_o;
  logic                       res_ready_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] va [8];
  logic [7:0] vb [8];

  always #5 clk_i = ~clk_i;

  mac_pe_feeder #(
    .InDataWidth (InW),
    .NumInputs   (NIn),
    .OutDataWidth(OutW),
    .MaxK        (MaxK),
    .KWidth      (KW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .k_beats_i     (k_beats_i),
    .busy_o        (busy_o),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .pe_a_o        (pe_a_o),
    .pe_b_o        (pe_b_o),
    .pe_a_valid_o  (pe_a_valid_o),
    .pe_b_valid_o  (pe_b_valid_o),
    .pe_init_save_o(pe_init_save_o),
    .pe_acc_clr_o  (pe_acc_clr_o),
    .pe_c_i        (pe_c),
    .res_o         (res_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i)
  );

  general_mac_pe #(
    .InDataWidth (InW),
    .NumInputs   (NIn),
    .OutDataWidth(OutW)
  ) pe (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .a_i        (pe_a_o),
    .b_i        (pe_b_o),
    .a_valid_i  (pe_a_valid_o),
    .b_valid_i  (pe_b_valid_o),
    .init_save_i(pe_init_save_o),
    .acc_clr_i  (pe_acc_clr_o),
    .c_o        (pe_c)
  );

  // Runs one job; cycle 0 is the start cycle. Returns observations, does no checking.
  task automatic run_job(input int k, input logic [63:0] bub, output int lat,
                         output logic [31:0] res, output int fired, output int inits,
                         output int init_first, output int bub_strb, output int rdy_cnt);
    int idx;
    lat = -1; res = '0; fired = 0; inits = 0; init_first = 0; bub_strb = 0; rdy_cnt = 0;
    idx = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; k_beats_i = KW'(k); op_valid_i = 1'b0;
    @(negedge clk_i);
    if (op_ready_o) rdy_cnt++;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk_i); #1;
      start_i    = 1'b0;
      op_valid_i = !(c < 64 && bub[6'(c)]);
      op_a_i[0]  = va[idx % 8];
      op_b_i[0]  = vb[idx % 8];
      @(negedge clk_i);
      if (op_ready_o) rdy_cnt++;
      if (!op_valid_i && (pe_a_valid_o || pe_b_valid_o || pe_init_save_o)) bub_strb++;
      if (pe_a_valid_o && pe_b_valid_o) begin
        fired++;
        if (pe_init_save_o) begin
          inits++;
          if (fired == 1) init_first = 1;
        end
        idx++;
      end
      if (res_valid_o) begin
        lat = c;
        res = res_o;
        break;
      end
    end
    @(posedge clk_i); #1;
    op_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy_o, op_ready_o, pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o,
         res_valid_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 0000000", {busy_o, op_ready_o, pe_a_valid_o,
               pe_b_valid_o, pe_init_save_o, pe_acc_clr_o, res_valid_o});
    end
    checks++;
    if (res_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_res got %0d exp 0", res_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int lat, fired, inits, init_first, bs, rdy;
    logic [31:0] res;
    va = '{1, 2, 3, 4, 0, 0, 0, 0};
    vb = '{5, 6, 7, 8, 0, 0, 0, 0};
    run_job(4, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd70) begin errors++; $display("FAIL basic_res got %0d exp 70", res); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", lat); end
    checks++;
    if (inits != 1 || init_first != 1) begin
      errors++;
      $display("FAIL basic_init_save got cnt=%0d first=%0d exp cnt=1 first=1", inits,
               init_first);
    end
    checks++;
    if (fired != 4 || rdy != 4) begin
      errors++;
      $display("FAIL basic_beats got fired=%0d ready=%0d exp 4/4", fired, rdy);
    end
  endtask

  task automatic test_bubbles();
    int lat, fired, inits, init_first, bs, rdy;
    logic [31:0] res;
    logic [63:0] bub;
    bub = 64'd0;
    bub[2] = 1'b1;
    bub[4] = 1'b1;
    run_job(4, bub, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd70) begin errors++; $display("FAIL bubble_res got %0d exp 70", res); end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL bubble_latency got %0d exp 8", lat); end
    checks++;
    if (bs != 0 || fired != 4 || inits != 1) begin
      errors++;
      $display("FAIL bubble_strobes got bubble=%0d fired=%0d inits=%0d exp 0/4/1", bs, fired,
               inits);
    end
  endtask

  task automatic test_clear();
    int lat, fired, inits, init_first, bs, rdy;
    logic [31:0] res;
    va = '{8'h80, 8'h80, 0, 0, 0, 0, 0, 0};
    vb = '{8'h80, 8'h80, 0, 0, 0, 0, 0, 0};
    run_job(2, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd32768) begin errors++; $display("FAIL neg_res got %0d exp 32768", res); end
    va[0] = 8'd3;
    vb[0] = 8'hFE;
    run_job(1, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL clear_res got %0h exp fffffffa", res);
    end
    checks++;
    if (lat != 3 || inits != 1 || fired != 1) begin
      errors++;
      $display("FAIL k1_job got lat=%0d inits=%0d fired=%0d exp 3/1/1", lat, inits, fired);
    end
  endtask

  task automatic test_k_bounds();
    int lat, fired, inits, init_first, bs, rdy;
    logic [31:0] res;
    va = '{1, 1, 1, 1, 1, 1, 1, 1};
    vb = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_job(0, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd0 || lat != 2) begin
      errors++;
      $display("FAIL k0_job got res=%0d lat=%0d exp 0/2", res, lat);
    end
    checks++;
    if (rdy != 0 || fired != 0) begin
      errors++;
      $display("FAIL k0_ready got ready=%0d fired=%0d exp 0/0", rdy, fired);
    end
    run_job(int'(MaxK) + 5, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (fired != 256 || res !== 32'd256) begin
      errors++;
      $display("FAIL clamp_beats got fired=%0d res=%0d exp 256/256", fired, res);
    end
    checks++;
    if (lat != 258) begin errors++; $display("FAIL clamp_latency got %0d exp 258", lat); end
  endtask

  task automatic test_hold();
    int lat, fired, inits, init_first, bs, rdy;
    int bad;
    logic [31:0] res;
    res_ready_i = 1'b0;
    va[0] = 8'd5;
    vb[0] = 8'd5;
    run_job(1, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd25 || lat != 3) begin
      errors++;
      $display("FAIL hold_res got res=%0d lat=%0d exp 25/3", res, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b1; k_beats_i = KW'(2);
      @(negedge clk_i);
      if (!res_valid_o || res_o !== 32'd25 || !busy_o || op_ready_o) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    @(posedge clk_i); #1;
    start_i = 1'b0; res_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_handshake_cycle got valid=%b exp 1", res_valid_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle got busy=%b valid=%b exp 0/0", busy_o, res_valid_o);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat, fired, inits, init_first, bs, rdy;
    logic [31:0] res;
    @(posedge clk_i); #1;
    start_i = 1'b1; k_beats_i = KW'(4);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0; op_valid_i = 1'b1;
      op_a_i[0] = 8'(i + 1); op_b_i[0] = 8'(i + 5);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({busy_o, op_ready_o, pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o,
         res_valid_o} !== 7'b0 || res_o !== 32'd0 || pe_c !== 32'd0) begin
      errors++;
      $display("FAIL midjob_reset got busy=%b rdy=%b v=%b res=%0d acc=%0d exp all 0", busy_o,
               op_ready_o, pe_a_valid_o, res_o, pe_c);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; op_valid_i = 1'b0;
    va[0] = 8'd7;
    vb[0] = 8'd7;
    run_job(1, 64'd0, lat, res, fired, inits, init_first, bs, rdy);
    checks++;
    if (res !== 32'd49 || lat != 3) begin
      errors++;
      $display("FAIL post_reset_job got res=%0d lat=%0d exp 49/3", res, lat);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    k_beats_i   = '0;
    op_a_i      = '0;
    op_b_i      = '0;
    op_valid_i  = 1'b0;
    res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    test_reset();
    test_basic();
    test_bubbles();
    test_clear();
    test_k_bounds();
    test_hold();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
